id_ex_stage: RTL and testbench

ID/EX pipeline register and EX operand-select stage for the 5-stage RV32I core. It captures decoded instruction fields from ID on each clock edge and applies stall, flush and load-use bubble control. From the registered fields and the EX/MEM and MEM/WB writeback buses, it combinationally produces the forwarded ALU operands `alu_a` and `alu_b`, and the store data, for the ALU directly downstream. It also raises the load-use hazard request that freezes IF/ID.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/id_ex_stage_if.sv | 61 ++++++
 rtl/id_ex_stage.sv | 125 ++++++++++++
 tb/tb_id_ex_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core parameters and the ALU operation encoding.
package riscv_pkg;

  parameter int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of ID-side fields, pipeline control, writeback forwarding buses and EX-stage outputs.
interface id_ex_stage_if #(parameter int XLEN = riscv_pkg::XLEN);
  import riscv_pkg::*;

  logic            stall;
  logic            flush;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1_addr;
  logic [4:0]      id_rs2_addr;
  logic [4:0]      id_rd_addr;
  alu_op_t         id_alu_op;
  logic            id_alu_src_a;
  logic            id_alu_src_b;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;

  logic            exmem_reg_write;
  logic [4:0]      exmem_rd_addr;
  logic [XLEN-1:0] exmem_result;
  logic            memwb_reg_write;
  logic [4:0]      memwb_rd_addr;
  logic [XLEN-1:0] memwb_result;

  logic            ex_valid;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic [XLEN-1:0] ex_pc;
  logic [4:0]      ex_rd_addr;
  alu_op_t         ex_alu_op;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] ex_store_data;
  logic            load_use_hazard;

  modport master (
    output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op, id_alu_src_a,
           id_alu_src_b, id_reg_write, id_mem_read, id_mem_write,
           exmem_reg_write, exmem_rd_addr, exmem_result,
           memwb_reg_write, memwb_rd_addr, memwb_result,
    input  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_pc,
           ex_rd_addr, ex_alu_op, alu_a, alu_b, ex_store_data, load_use_hazard
  );

  modport slave (
    input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op, id_alu_src_a,
           id_alu_src_b, id_reg_write, id_mem_read, id_mem_write,
           exmem_reg_write, exmem_rd_addr, exmem_result,
           memwb_reg_write, memwb_rd_addr, memwb_result,
    output ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_pc,
           ex_rd_addr, ex_alu_op, alu_a, alu_b, ex_store_data, load_use_hazard
  );

endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush/load-use bubble control, operand
// forwarding from EX/MEM and MEM/WB, and ALU operand selection.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            src_a;
    logic            src_b;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    alu_op_t         alu_op;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
  } ex_reg_t;

  localparam ex_reg_t BUBBLE = '{
    valid:     1'b0,
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    src_a:     1'b0,
    src_b:     1'b0,
    rs1_addr:  5'd0,
    rs2_addr:  5'd0,
    rd_addr:   5'd0,
    alu_op:    ALU_ADD,
    pc:        '0,
    rs1_data:  '0,
    rs2_data:  '0,
    imm:       '0
  };

  ex_reg_t ex_q;
  ex_reg_t id_fields;
  logic    hazard;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  always_comb begin
    id_fields           = BUBBLE;
    id_fields.valid     = bus.id_valid;
    id_fields.reg_write = bus.id_reg_write;
    id_fields.mem_read  = bus.id_mem_read;
    id_fields.mem_write = bus.id_mem_write;
    id_fields.src_a     = bus.id_alu_src_a;
    id_fields.src_b     = bus.id_alu_src_b;
    id_fields.rs1_addr  = bus.id_rs1_addr;
    id_fields.rs2_addr  = bus.id_rs2_addr;
    id_fields.rd_addr   = bus.id_rd_addr;
    id_fields.alu_op    = bus.id_alu_op;
    id_fields.pc        = bus.id_pc;
    id_fields.rs1_data  = bus.id_rs1_data;
    id_fields.rs2_data  = bus.id_rs2_data;
    id_fields.imm       = bus.id_imm;
  end

  // Both rs fields are compared even if unused; a flush suppresses the request.
  always_comb begin
    hazard = ~bus.flush & bus.id_valid & ex_q.valid & ex_q.mem_read &
             (ex_q.rd_addr != 5'd0) &
             ((ex_q.rd_addr == bus.id_rs1_addr) | (ex_q.rd_addr == bus.id_rs2_addr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= BUBBLE;
    end else if (bus.flush) begin
      ex_q <= BUBBLE;
    end else if (bus.stall) begin
      ex_q <= ex_q;
    end else if (hazard) begin
      ex_q <= BUBBLE;
    end else begin
      ex_q <= id_fields;
    end
  end

  // EX/MEM is the younger result and takes precedence; x0 is never forwarded.
  always_comb begin
    rs1_fwd = ex_q.rs1_data;
    if (bus.exmem_reg_write && bus.exmem_rd_addr != 5'd0 &&
        bus.exmem_rd_addr == ex_q.rs1_addr) begin
      rs1_fwd = bus.exmem_result;
    end else if (bus.memwb_reg_write && bus.memwb_rd_addr != 5'd0 &&
                 bus.memwb_rd_addr == ex_q.rs1_addr) begin
      rs1_fwd = bus.memwb_result;
    end
  end

  always_comb begin
    rs2_fwd = ex_q.rs2_data;
    if (bus.exmem_reg_write && bus.exmem_rd_addr != 5'd0 &&
        bus.exmem_rd_addr == ex_q.rs2_addr) begin
      rs2_fwd = bus.exmem_result;
    end else if (bus.memwb_reg_write && bus.memwb_rd_addr != 5'd0 &&
                 bus.memwb_rd_addr == ex_q.rs2_addr) begin
      rs2_fwd = bus.memwb_result;
    end
  end

  assign bus.ex_valid        = ex_q.valid;
  assign bus.ex_reg_write    = ex_q.reg_write;
  assign bus.ex_mem_read     = ex_q.mem_read;
  assign bus.ex_mem_write    = ex_q.mem_write;
  assign bus.ex_pc           = ex_q.pc;
  assign bus.ex_rd_addr      = ex_q.rd_addr;
  assign bus.ex_alu_op       = ex_q.alu_op;
  assign bus.alu_a           = ex_q.src_a ? ex_q.pc  : rs1_fwd;
  assign bus.alu_b           = ex_q.src_b ? ex_q.imm : rs2_fwd;
  assign bus.ex_store_data   = rs2_fwd;
  assign bus.load_use_hazard = hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, forwarding, load-use,
// stall hold, flush priority and asynchronous reset.
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [31:0] rs1d, input logic [4:0] rs2,
                          input logic [31:0] rs2d, input logic [4:0] rd,
                          input logic [31:0] imm, input logic sa, input logic sb,
                          input logic mr, input logic mw);
    bus.id_valid     = 1'b1;
    bus.id_pc        = pc;
    bus.id_rs1_addr  = rs1;
    bus.id_rs1_data  = rs1d;
    bus.id_rs2_addr  = rs2;
    bus.id_rs2_data  = rs2d;
    bus.id_rd_addr   = rd;
    bus.id_imm       = imm;
    bus.id_alu_src_a = sa;
    bus.id_alu_src_b = sb;
    bus.id_mem_read  = mr;
    bus.id_mem_write = mw;
    bus.id_reg_write = ~mw;
    bus.id_alu_op    = ALU_SUB;
  endtask

  task automatic clear_fwd();
    bus.exmem_reg_write = 1'b0;
    bus.exmem_rd_addr   = 5'd0;
    bus.exmem_result    = '0;
    bus.memwb_reg_write = 1'b0;
    bus.memwb_rd_addr   = 5'd0;
    bus.memwb_result    = '0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    clear_fwd();
    drive_id($urandom, 5'($urandom), $urandom, 5'($urandom), $urandom,
             5'($urandom), $urandom, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.id_alu_op = alu_op_t'($urandom_range(1, 9));
    tick();
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_ex_valid got %b want 0", bus.ex_valid);
    end
    checks++;
    if (bus.ex_reg_write !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_ex_reg_write got %b want 0", bus.ex_reg_write);
    end
    checks++;
    if (bus.ex_alu_op !== ALU_ADD) begin
      failures++; $display("[TB] FAIL reset_ex_alu_op got %0d want 0", bus.ex_alu_op);
    end
    checks++;
    if (bus.alu_a !== 32'h0 || bus.alu_b !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_alu_ab got %h/%h want 0/0", bus.alu_a, bus.alu_b);
    end
    rst_n = 1'b1;
    drive_id(32'h100, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.alu_a !== 32'h100 || bus.alu_b !== 32'h4) begin
      failures++; $display("[TB] FAIL first_capture_alu_ab got %h/%h want 100/4", bus.alu_a, bus.alu_b);
    end
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_alu_op !== ALU_SUB || bus.ex_rd_addr !== 5'd3) begin
      failures++; $display("[TB] FAIL first_capture_ctrl got v=%b op=%0d rd=%0d want v=1 op=1 rd=3",
                           bus.ex_valid, bus.ex_alu_op, bus.ex_rd_addr);
    end
  endtask

  task automatic test_forwarding();
    drive_id(32'h110, 5'd5, 32'h1111, 5'd6, 32'h2222, 5'd4, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.exmem_reg_write = 1'b1; bus.exmem_rd_addr = 5'd5; bus.exmem_result = 32'hAAAA;
    bus.memwb_reg_write = 1'b1; bus.memwb_rd_addr = 5'd5; bus.memwb_result = 32'hBBBB;
    #1;
    checks++;
    if (bus.alu_a !== 32'hAAAA) begin
      failures++; $display("[TB] FAIL fwd_exmem_priority got %h want AAAA", bus.alu_a);
    end
    bus.exmem_reg_write = 1'b0;
    #1;
    checks++;
    if (bus.alu_a !== 32'hBBBB) begin
      failures++; $display("[TB] FAIL fwd_memwb got %h want BBBB", bus.alu_a);
    end
    bus.exmem_reg_write = 1'b1; bus.exmem_rd_addr = 5'd0;
    bus.memwb_rd_addr   = 5'd0;
    #1;
    checks++;
    if (bus.alu_a !== 32'h1111) begin
      failures++; $display("[TB] FAIL fwd_x0_none got %h want 1111", bus.alu_a);
    end
    bus.memwb_rd_addr = 5'd6;
    #1;
    checks++;
    if (bus.alu_b !== 32'hBBBB || bus.ex_store_data !== 32'hBBBB) begin
      failures++; $display("[TB] FAIL fwd_rs2 got alu_b=%h store=%h want BBBB/BBBB",
                           bus.alu_b, bus.ex_store_data);
    end
    clear_fwd();
    #1;
    checks++;
    if (bus.ex_store_data !== 32'h2222) begin
      failures++; $display("[TB] FAIL store_data_plain got %h want 2222", bus.ex_store_data);
    end
  endtask

  task automatic test_load_use();
    drive_id(32'h120, 5'd2, 32'h0, 5'd0, 32'h0, 5'd7, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(32'h124, 5'd7, 32'h5, 5'd1, 32'h6, 5'd8, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.load_use_hazard !== 1'b1) begin
      failures++; $display("[TB] FAIL load_use_detect got %b want 1", bus.load_use_hazard);
    end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_rd_addr !== 5'd0 || bus.load_use_hazard !== 1'b0) begin
      failures++; $display("[TB] FAIL load_use_bubble got v=%b rd=%0d hz=%b want 0/0/0",
                           bus.ex_valid, bus.ex_rd_addr, bus.load_use_hazard);
    end
    tick();
    bus.memwb_reg_write = 1'b1; bus.memwb_rd_addr = 5'd7; bus.memwb_result = 32'h77;
    #1;
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rd_addr !== 5'd8 || bus.alu_a !== 32'h77) begin
      failures++; $display("[TB] FAIL load_use_capture got v=%b rd=%0d a=%h want 1/8/77",
                           bus.ex_valid, bus.ex_rd_addr, bus.alu_a);
    end
    clear_fwd();
  endtask

  task automatic test_load_use_x0();
    drive_id(32'h130, 5'd2, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(32'h134, 5'd0, 32'h0, 5'd1, 32'h0, 5'd8, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.load_use_hazard !== 1'b0) begin
      failures++; $display("[TB] FAIL load_use_x0 got %b want 0", bus.load_use_hazard);
    end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h134) begin
      failures++; $display("[TB] FAIL load_use_x0_capture got v=%b pc=%h want 1/134",
                           bus.ex_valid, bus.ex_pc);
    end
  endtask

  task automatic test_stall();
    drive_id(32'h200, 5'd2, 32'h0, 5'd0, 32'h0, 5'd9, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(32'h204, 5'd9, 32'h0, 5'd3, 32'h0, 5'd11, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.id_pc      = 32'h300 + 32'(4 * i);
      bus.id_rd_addr = 5'(12 + i);
      tick();
      checks++;
      if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h200 || bus.ex_rd_addr !== 5'd9 ||
          bus.ex_mem_read !== 1'b1 || bus.load_use_hazard !== 1'b1) begin
        failures++; $display("[TB] FAIL stall_hold_%0d got v=%b pc=%h rd=%0d mr=%b hz=%b want 1/200/9/1/1",
                             i, bus.ex_valid, bus.ex_pc, bus.ex_rd_addr, bus.ex_mem_read,
                             bus.load_use_hazard);
      end
    end
    bus.stall = 1'b0;
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL stall_release_bubble got %b want 0", bus.ex_valid);
    end
    tick();
    checks++;
    if (bus.ex_pc !== 32'h308 || bus.ex_rd_addr !== 5'd14) begin
      failures++; $display("[TB] FAIL stall_release_capture got pc=%h rd=%0d want 308/14",
                           bus.ex_pc, bus.ex_rd_addr);
    end
  endtask

  task automatic test_flush();
    drive_id(32'h400, 5'd2, 32'h0, 5'd0, 32'h0, 5'd10, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(32'h404, 5'd2, 32'h0, 5'd10, 32'h0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.load_use_hazard !== 1'b1) begin
      failures++; $display("[TB] FAIL flush_pre_hazard got %b want 1", bus.load_use_hazard);
    end
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    #1;
    checks++;
    if (bus.load_use_hazard !== 1'b0) begin
      failures++; $display("[TB] FAIL flush_hazard_masked got %b want 0", bus.load_use_hazard);
    end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_mem_write !== 1'b0 || bus.ex_mem_read !== 1'b0) begin
      failures++; $display("[TB] FAIL flush_over_stall got v=%b mw=%b mr=%b want 0/0/0",
                           bus.ex_valid, bus.ex_mem_write, bus.ex_mem_read);
    end
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    tick();
    checks++;
    if (bus.ex_mem_write !== 1'b1 || bus.ex_pc !== 32'h404) begin
      failures++; $display("[TB] FAIL flush_recover got mw=%b pc=%h want 1/404",
                           bus.ex_mem_write, bus.ex_pc);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_pc !== 32'h0 || bus.ex_mem_write !== 1'b0) begin
      failures++; $display("[TB] FAIL async_reset got v=%b pc=%h mw=%b want 0/0/0",
                           bus.ex_valid, bus.ex_pc, bus.ex_mem_write);
    end
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_load_use_x0();
    test_stall();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
